// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-lite response codes and FSM state types
package axi_lite_pkg;

  localparam int RESP_W = 2;

  typedef enum logic [RESP_W-1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rstate_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - register bank with one write port, one combinational read port and flat export
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [IDX_W-1:0]        ridx,
  output logic [DATA_W-1:0]       rdata,
  output logic [NREGS*DATA_W-1:0] regs_o
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: rtl/axi_lite_slave.sv
// rtl/axi_lite_slave.sv - AXI-lite responder: address decode, write/read FSMs, register bank export
module axi_lite_slave
  import axi_lite_pkg::*;
#(
  parameter int               ADDR_W = 32,
  parameter int               DATA_W = 32,
  parameter int               NREGS  = 16,
  parameter logic [ADDR_W-1:0] BASE  = '0,
  localparam int              IDX_W  = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    awvalid,
  input  logic [ADDR_W-1:0]       awaddr,
  output logic                    awready,
  input  logic                    wvalid,
  input  logic [DATA_W-1:0]       wdata,
  output logic                    wready,
  output logic                    bvalid,
  output logic [RESP_W-1:0]       bresp,
  input  logic                    bready,
  input  logic                    arvalid,
  input  logic [ADDR_W-1:0]       araddr,
  output logic                    arready,
  output logic                    rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic [RESP_W-1:0]       rresp,
  input  logic                    rready,
  output logic [NREGS*DATA_W-1:0] regs_o,
  output logic                    wr_strobe,
  output logic [IDX_W-1:0]        wr_idx
);

  localparam int AL = $clog2(DATA_W / 8);

  wstate_t           wstate_q, wstate_d;
  rstate_t           rstate_q, rstate_d;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              commit;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic [ADDR_W-1:0] w_off, r_off;
  logic              w_ok, r_ok;
  logic [IDX_W-1:0]  w_idx, r_idx;
  logic [DATA_W-1:0] rd_word;

  // In range and word aligned; NREGS is a power of two so the range test is a high-bit check.
  assign w_off = commit_addr - BASE;
  assign w_ok  = ((w_off >> (AL + IDX_W)) == '0) && (w_off[AL-1:0] == '0);
  assign w_idx = w_off[AL +: IDX_W];

  assign r_off = araddr - BASE;
  assign r_ok  = ((r_off >> (AL + IDX_W)) == '0) && (r_off[AL-1:0] == '0);
  assign r_idx = r_off[AL +: IDX_W];

  always_comb begin
    wstate_d    = wstate_q;
    awready     = 1'b0;
    wready      = 1'b0;
    commit      = 1'b0;
    commit_addr = awaddr;
    commit_data = wdata;
    unique case (wstate_q)
      W_IDLE: begin
        awready = ~rst;
        wready  = ~rst;
        if (awvalid && wvalid) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end else if (awvalid) begin
          wstate_d = W_HAVE_A;
        end else if (wvalid) begin
          wstate_d = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        wready      = ~rst;
        commit_addr = awaddr_q;
        if (wvalid) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end
      end
      W_HAVE_D: begin
        awready     = ~rst;
        commit_data = wdata_q;
        if (awvalid) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end
      end
      W_RESP: begin
        if (bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
      wr_strobe <= 1'b0;
      wr_idx    <= '0;
    end else begin
      wstate_q  <= wstate_d;
      wr_strobe <= commit && w_ok;
      if (commit && w_ok) wr_idx <= w_idx;
      if (wstate_q == W_IDLE && awvalid) awaddr_q <= awaddr;
      if (wstate_q == W_IDLE && wvalid && !awvalid) wdata_q <= wdata;
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= w_ok ? OKAY : SLVERR;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    arready  = 1'b0;
    unique case (rstate_q)
      R_IDLE: begin
        arready = ~rst;
        if (arvalid) rstate_d = R_RESP;
      end
      R_RESP: begin
        if (rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // The bank read here sees pre-commit contents, so a same-edge write to the same index is not visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q <= R_IDLE;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= OKAY;
    end else begin
      rstate_q <= rstate_d;
      if (rstate_q == R_IDLE && arvalid) begin
        rvalid <= 1'b1;
        rdata  <= r_ok ? rd_word : '0;
        rresp  <= r_ok ? OKAY : SLVERR;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  axi_lite_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (commit && w_ok),
    .widx  (w_idx),
    .wdata (commit_data),
    .ridx  (r_idx),
    .rdata (rd_word),
    .regs_o(regs_o)
  );

endmodule

// File: tb/tb_axi_lite_slave.sv
// tb/tb_axi_lite_slave.sv - self-checking bench for axi_lite_slave against an array reference model
module tb_axi_lite_slave;

  localparam int NREGS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic        awready, wready, bvalid, arready, rvalid, wr_strobe;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [NREGS*32-1:0] regs_o;
  logic [3:0]  wr_idx;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [NREGS];
  logic [3:0]  commit_q [$];
  int          b_hs = 0;

  axi_lite_slave dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .regs_o(regs_o), .wr_strobe(wr_strobe), .wr_idx(wr_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe) commit_q.push_back(wr_idx);
    if (bvalid && bready) b_hs++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit addr_ok(input logic [31:0] addr);
    return (addr < NREGS * 4) && (addr % 4 == 0);
  endfunction

  function automatic logic [NREGS*32-1:0] model_flat();
    logic [NREGS*32-1:0] f;
    for (int i = 0; i < NREGS; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly,
                           output logic [1:0] resp, output int lat);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      awaddr  = addr;
      wdata   = data;
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid  = !w_done && cyc >= w_dly;
      #1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
    end
    awvalid = 0;
    wvalid  = 0;
    lat = 1;
    while (!bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    resp = bresp;
    bready = 1;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rdly,
                          output logic [31:0] data, output logic [1:0] resp,
                          output int lat, output bit held);
    bit hs = 0;
    int cyc = 0;
    araddr = addr;
    while (!hs && cyc < 50) begin
      arvalid = 1;
      #1;
      hs = arready;
      @(negedge clk);
      cyc++;
    end
    arvalid = 0;
    lat = 1;
    while (!rvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    data = rdata;
    resp = rresp;
    held = 1;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      if (rvalid !== 1'b1 || rdata !== data || rresp !== resp || arready !== 1'b0) held = 0;
    end
    rready = 1;
    @(negedge clk);
    rready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({awready, wready, arready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b exp 000", {awready, wready, arready});
    end
    n_tests++;
    if ({bvalid, rvalid, bresp, rresp, wr_strobe, wr_idx} !== '0 || rdata !== '0) begin
      n_fail++; $display("FAIL reset_outputs: bv=%b rv=%b br=%b rr=%b rd=%h st=%b idx=%h exp all 0",
                         bvalid, rvalid, bresp, rresp, rdata, wr_strobe, wr_idx);
    end
    n_tests++;
    if (regs_o !== '0) begin
      n_fail++; $display("FAIL reset_regs: got %h exp 0", regs_o);
    end
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    rst = 0;
    @(negedge clk);
    n_tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_release_ready: got %b exp 111", {awready, wready, arready});
    end
  endtask

  task automatic test_write_same_cycle();
    logic [1:0] resp;
    int lat, c0;
    c0 = commit_q.size();
    axi_write(32'h4, 32'hA5A5_0001, 0, 0, resp, lat);
    model[1] = 32'hA5A5_0001;
    n_tests++;
    if (lat !== 1 || resp !== 2'b00) begin
      n_fail++; $display("FAIL same_cycle_b: lat=%0d resp=%b exp lat=1 resp=00", lat, resp);
    end
    n_tests++;
    if (commit_q.size() != c0 + 1 || commit_q[$] !== 4'd1) begin
      n_fail++; $display("FAIL same_cycle_strobe: commits=%0d exp %0d", commit_q.size() - c0, 1);
    end
    n_tests++;
    if (regs_o[32 +: 32] !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL same_cycle_reg1: got %h exp a5a50001", regs_o[32 +: 32]);
    end
  endtask

  task automatic test_w_before_aw();
    bit seq_ok = 1;
    awvalid = 0; wvalid = 1; wdata = 32'h1234;
    #1;
    if (wready !== 1'b1) seq_ok = 0;
    @(negedge clk);
    wvalid = 0;
    for (int i = 1; i < 3; i++) begin
      #1;
      if (wready !== 1'b0 || awready !== 1'b1 || wr_strobe !== 1'b0) seq_ok = 0;
      @(negedge clk);
    end
    awvalid = 1; awaddr = 32'h8;
    #1;
    if (wready !== 1'b0 || awready !== 1'b1) seq_ok = 0;
    @(negedge clk);
    awvalid = 0;
    n_tests++;
    if (!seq_ok) begin
      n_fail++; $display("FAIL w_first_ready_seq: ready sequence wrong, exp wready=0 awready=1 while waiting");
    end
    model[2] = 32'h1234;
    n_tests++;
    if (wr_strobe !== 1'b1 || wr_idx !== 4'd2 || regs_o[64 +: 32] !== 32'h1234) begin
      n_fail++; $display("FAIL w_first_commit: st=%b idx=%0d reg2=%h exp 1 2 00001234", wr_strobe, wr_idx, regs_o[64 +: 32]);
    end
    n_tests++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
      n_fail++; $display("FAIL w_first_b: bv=%b br=%b awr=%b wr=%b exp 1 00 0 0", bvalid, bresp, awready, wready);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    n_tests++;
    if (bvalid !== 1'b0 || wr_strobe !== 1'b0) begin
      n_fail++; $display("FAIL w_first_b_done: bv=%b st=%b exp 0 0", bvalid, wr_strobe);
    end
  endtask

  task automatic test_read_hold();
    logic [31:0] d; logic [1:0] r; int lat; bit held;
    axi_read(32'h4, 5, d, r, lat, held);
    n_tests++;
    if (d !== model[1] || r !== 2'b00 || lat !== 1) begin
      n_fail++; $display("FAIL read_hold_data: got %h/%b lat=%0d exp %h/00 lat=1", d, r, lat, model[1]);
    end
    n_tests++;
    if (!held) begin
      n_fail++; $display("FAIL read_hold_stable: got unstable exp stable with arready=0");
    end
    n_tests++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      n_fail++; $display("FAIL read_hold_done: rv=%b arr=%b exp 0 1", rvalid, arready);
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp; int lat, c0; logic [31:0] d; bit held;
    c0 = commit_q.size();
    axi_write(32'h100, 32'hFFFF, 0, 0, resp, lat);
    n_tests++;
    if (resp !== (addr_ok(32'h100) ? 2'b00 : 2'b10) || lat !== 1) begin
      n_fail++; $display("FAIL err_write_resp: got %b lat=%0d exp 10 lat=1", resp, lat);
    end
    n_tests++;
    if (commit_q.size() != c0 || regs_o !== model_flat()) begin
      n_fail++; $display("FAIL err_write_nocommit: commits=%0d regs=%h exp 0 %h", commit_q.size() - c0, regs_o, model_flat());
    end
    axi_read(32'h6, 0, d, resp, lat, held);
    n_tests++;
    if (resp !== 2'b10 || d !== 32'h0 || lat !== 1) begin
      n_fail++; $display("FAIL err_read: got %h/%b lat=%0d exp 0/10 lat=1", d, resp, lat);
    end
  endtask

  task automatic test_collision();
    logic [31:0] old, d; logic [1:0] r; int lat; bit held;
    old = model[3];
    awvalid = 1; awaddr = 32'hC; wvalid = 1; wdata = 32'h55;
    arvalid = 1; araddr = 32'hC; bready = 1; rready = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    model[3] = 32'h55;
    n_tests++;
    if (rvalid !== 1'b1 || rdata !== old || rresp !== 2'b00) begin
      n_fail++; $display("FAIL collide_old: rv=%b rd=%h rr=%b exp 1 %h 00", rvalid, rdata, rresp, old);
    end
    n_tests++;
    if (bvalid !== 1'b1 || wr_strobe !== 1'b1 || wr_idx !== 4'd3) begin
      n_fail++; $display("FAIL collide_write: bv=%b st=%b idx=%0d exp 1 1 3", bvalid, wr_strobe, wr_idx);
    end
    @(negedge clk);
    bready = 0; rready = 0;
    axi_read(32'hC, 0, d, r, lat, held);
    n_tests++;
    if (d !== 32'h55 || r !== 2'b00) begin
      n_fail++; $display("FAIL collide_new: got %h/%b exp 00000055/00", d, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    logic [3:0]  idxs [5];
    int k = 0, cyc = 0;
    bit hs;
    for (int i = 0; i < 5; i++) idxs[i] = 4'($urandom_range(0, NREGS - 1));
    rready = 1;
    while (got.size() < 4 && cyc < 20) begin
      araddr  = 32'(idxs[k]) * 4;
      arvalid = (k < 4);
      #1;
      if (rvalid) got.push_back(rdata);
      hs = arvalid && arready;
      @(negedge clk);
      cyc++;
      if (hs) k++;
    end
    arvalid = 0; rready = 0;
    n_tests++;
    if (cyc != 8 || got.size() != 4) begin
      n_fail++; $display("FAIL b2b_rate: got %0d reads in %0d cycles exp 4 in 8", got.size(), cyc);
    end
    for (int i = 0; i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== model[idxs[i]]) begin
        n_fail++; $display("FAIL b2b_data%0d: got %h exp %h", i, got[i], model[idxs[i]]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, data, d; logic [1:0] resp; int lat, c0, sel; bit held, ok;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) addr = 32'($urandom_range(0, NREGS - 1)) * 4;
      else if (sel < 9) addr = 32'($urandom_range(0, 255));
      else addr = $urandom;
      ok = addr_ok(addr);
      if ($urandom_range(0, 1) == 0) begin
        data = $urandom;
        c0 = commit_q.size();
        axi_write(addr, data, $urandom_range(0, 3), $urandom_range(0, 3), resp, lat);
        if (ok) model[addr / 4] = data;
        n_tests++;
        if (resp !== (ok ? 2'b00 : 2'b10) || lat !== 1) begin
          n_fail++; $display("FAIL rnd_write_resp @%h: got %b lat=%0d exp %b lat=1", addr, resp, lat, ok ? 2'b00 : 2'b10);
        end
        n_tests++;
        if (commit_q.size() != c0 + (ok ? 1 : 0) || (ok && commit_q[$] !== 4'(addr / 4))) begin
          n_fail++; $display("FAIL rnd_write_commit @%h: commits=%0d exp %0d", addr, commit_q.size() - c0, ok ? 1 : 0);
        end
        n_tests++;
        if (regs_o !== model_flat()) begin
          n_fail++; $display("FAIL rnd_regs @%h: got %h exp %h", addr, regs_o, model_flat());
        end
      end else begin
        axi_read(addr, $urandom_range(0, 2), d, resp, lat, held);
        n_tests++;
        if (d !== (ok ? model[addr / 4] : 32'h0) || resp !== (ok ? 2'b00 : 2'b10) || lat !== 1 || !held) begin
          n_fail++; $display("FAIL rnd_read @%h: got %h/%b lat=%0d held=%0d exp %h/%b lat=1",
                             addr, d, resp, lat, held, ok ? model[addr / 4] : 32'h0, ok ? 2'b00 : 2'b10);
        end
      end
    end
  endtask

  task automatic test_reset_abandon();
    logic [1:0] resp; int lat, b0, c0;
    axi_write(32'h0, 32'hDEAD_BEEF, 0, 0, resp, lat);
    model[0] = 32'hDEAD_BEEF;
    awvalid = 1; awaddr = 32'h10; wvalid = 0;
    @(negedge clk);
    awvalid = 0;
    wvalid = 1; wdata = 32'h7777; rst = 1;
    b0 = b_hs; c0 = commit_q.size();
    @(negedge clk);
    n_tests++;
    if ({awready, wready, arready, bvalid, rvalid, wr_strobe} !== '0 ||
        {bresp, rresp, wr_idx} !== '0 || rdata !== '0) begin
      n_fail++; $display("FAIL abandon_outputs: rdy=%b bv=%b rv=%b st=%b idx=%0d exp all 0",
                         {awready, wready, arready}, bvalid, rvalid, wr_strobe, wr_idx);
    end
    n_tests++;
    if (regs_o !== '0) begin
      n_fail++; $display("FAIL abandon_regs: idx0=%h exp all 0", regs_o[31:0]);
    end
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    wvalid = 0; rst = 0; bready = 1;
    repeat (4) @(negedge clk);
    bready = 0;
    n_tests++;
    if (b_hs != b0 || commit_q.size() != c0 || bvalid !== 1'b0) begin
      n_fail++; $display("FAIL abandon_no_b: b=%0d commits=%0d exp 0 0", b_hs - b0, commit_q.size() - c0);
    end
    n_tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL abandon_ready: got %b exp 111", {awready, wready, arready});
    end
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_read_hold();
    test_errors();
    test_collision();
    test_random();
    test_back_to_back();
    test_reset_abandon();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave.md
# axi_lite_slave

AXI-lite responder terminating one crossbar slave port, with an internal register bank of `NREGS` words. It is the far end of the AXI-lite master used by the DMA and CPU. It accepts AW and W independently in either order and returns B and R responses with full valid/ready handshakes. Register contents are exported flat for downstream control logic, and every committed write is signalled with a one-cycle strobe.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; must be 32 or 64.
- `NREGS`, 16, number of registers; must be a power of 2 and at least 2.
- `BASE`, 32'h0, byte base address of the bank.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `awvalid`  in  1  write-address valid.
- `awaddr`  in  ADDR_W  write byte address.
- `awready`  out  1  write-address accepted.
- `wvalid`  in  1  write-data valid.
- `wdata`  in  DATA_W  write data.
- `wready`  out  1  write data accepted.
- `bvalid`  out  1  write response valid.
- `bresp`  out  2  write response: 00 OKAY, 10 SLVERR.
- `bready`  in  1  master accepts the write response.
- `arvalid`  in  1  read-address valid.
- `araddr`  in  ADDR_W  read byte address.
- `arready`  out  1  read address accepted.
- `rvalid`  out  1  read data valid.
- `rdata`  out  DATA_W  read data.
- `rresp`  out  2  read response, same encoding as `bresp`.
- `rready`  in  1  master accepts the read data.
- `regs_o`  out  NREGS*DATA_W  register contents; register i occupies bits [i*DATA_W +: DATA_W].
- `wr_strobe`  out  1  one-cycle pulse on every committed write.
- `wr_idx`  out  $clog2(NREGS)  index of the committed register; valid while `wr_strobe` is high.

## Operation
Address decode:
- offset = addr − `BASE`.
- Valid when offset < NREGS*(DATA_W/8) and offset is word-aligned.
- Register index = offset / (DATA_W/8).
- Invalid address:
  - write is dropped, `bresp` = SLVERR;
  - read returns `rdata` = 0, `rresp` = SLVERR.

Write FSM states: `W_IDLE`, `W_HAVE_A`, `W_HAVE_D`, `W_RESP`.
- `W_IDLE`: `awready` = `wready` = 1.
  - Both valid → capture both, go to `W_RESP`.
  - AW only → capture address, go to `W_HAVE_A`.
  - W only → capture data, go to `W_HAVE_D`.
- `W_HAVE_A`: `awready` = 0, `wready` = 1. On `wvalid` → go to `W_RESP`.
- `W_HAVE_D`: `wready` = 0, `awready` = 1. On `awvalid` → go to `W_RESP`.
- Entry into `W_RESP`, valid address: the register is updated on the same edge, and `wr_strobe`/`wr_idx` are high for exactly that cycle.
- `W_RESP`: `bvalid` = 1 and holds with `bresp` stable until `bready`, then go to `W_IDLE`. `awready` and `wready` are 0 while in `W_RESP`.

Read FSM states: `R_IDLE`, `R_RESP`.
- `R_IDLE`: `arready` = 1. On `arvalid` → register `rdata`/`rresp` from the bank contents at that edge, go to `R_RESP`.
- `R_RESP`: `rvalid` = 1, `arready` = 0. Hold `rdata`/`rresp` until `rready`, then go to `R_IDLE`.

Concurrency:
- The read and write FSMs are independent; simultaneous read and write are both serviced.
- A read whose AR handshake lands in the same cycle as a write commit to the same index returns the pre-write value.

Reset (synchronous, `rst` = 1 at a clock edge):
- All registers clear to 0; both FSMs return to IDLE.
- `awready` = `wready` = `arready` = 0 during reset.
- `bvalid` = `rvalid` = 0, `bresp` = `rresp` = 0, `rdata` = 0, `wr_strobe` = 0, `wr_idx` = 0.
- A transaction in flight when reset asserts is abandoned: no response, no commit.
- The ready outputs rise in the first cycle after `rst` deasserts.

## Timing
- All outputs are registered, except that the ready outputs are decoded from the FSM state register.
- Write latency: B response valid 1 cycle after the later of the AW/W handshakes.
- Read latency: R response valid 1 cycle after the AR handshake.
- Throughput: one write per 2 cycles with `bready` tied high; likewise one read per 2 cycles with `rready` tied high.
- Valid outputs never drop without the matching ready; payloads remain stable while valid is asserted.

## Structure
Package `axi_lite_pkg`, shared with the master:
- `resp_t` (OKAY = 2'b00, SLVERR = 2'b10);
- `wstate_t`, `rstate_t` enums;
- the constant `RESP_W` = 2.

Sub-module `axi_lite_regfile`:
- holds the `NREGS`×`DATA_W` storage;
- one write port (en, idx, data);
- one combinational read port;
- flat `regs_o` output.

The top level holds decode and both FSMs.

## Test plan
- Reset, then AW=0x4 and W=0xA5A5_0001 in the same cycle, `bready` = 1 → `bvalid` next cycle with OKAY; `wr_strobe` with `wr_idx` = 1; `regs_o` word 1 = 0xA5A5_0001.
- W=0x1234 three cycles before AW=0x8 → `wready` drops after the W handshake, `awready` stays 1; commit of idx 2 = 0x1234 one cycle after AW; `bvalid` follows.
- Read 0x4 with `rready` held low for 5 cycles → `rvalid` and `rdata` = 0xA5A5_0001 stable throughout; `arready` = 0 until the R handshake completes.
- AW=0x100 (out of range) plus W=0xFFFF, and a read of 0x6 (misaligned) → both responses SLVERR, `rdata` = 0, no `wr_strobe`, registers unchanged.
- Write 0x55 to idx 3 with the AR of idx 3 in the commit cycle → read returns the old value (0); a subsequent read returns 0x55.
- `rst` asserted with AW captured and W pending → next cycle all outputs are at reset values and idx 0 = 0; no B ever issued for the abandoned write.
